riscv_v_exe_seq: RTL and testbench

- Beat sequencer in front of the vector execute stage.
- Accepts one decoded vector instruction at a time and walks its LMUL register group one physical vector register per cycle.
- Drives the execute stage's register read/write addresses, element base, first/last flags and valid.
- Handles vl/vstart trimming, reductions, mask ops, memory-stage backpressure and illegal-configuration rejection.

---
 rtl/riscv_v_exe_seq_if.sv | 57 +++++
 rtl/riscv_v_exe_seq.sv | 186 ++++++++++++++++++
 tb/tb_riscv_v_exe_seq.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_v_exe_seq_if.sv
// +----------------------------------------------------------------------------+
// | Module   : riscv_v_exe_seq_if                                               |
// | Purpose  : Issue-side and execute-side signal bundle of the beat sequencer. |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface riscv_v_exe_seq_if #(
  parameter int VLEN     = 128,
  parameter int MAX_LMUL = 8,
  parameter int VL_W     = $clog2(VLEN*MAX_LMUL/8)+1
);
  logic            issue_valid;
  logic            issue_ready;
  logic [4:0]      vs1_addr;
  logic [4:0]      vs2_addr;
  logic [4:0]      vd_addr;
  logic [2:0]      vsew;
  logic [2:0]      vlmul;
  logic            vill;
  logic [VL_W-1:0] vl;
  logic [VL_W-1:0] vstart;
  logic            is_reduct;
  logic            is_mask;
  logic            is_scalar_op;
  logic            exe_stall;
  logic            exe_valid;
  logic [4:0]      rf_rd_addr_srca;
  logic [4:0]      rf_rd_addr_srcb;
  logic [4:0]      rf_wr_addr;
  logic            rf_wr_en;
  logic [2:0]      beat_idx;
  logic            beat_first;
  logic            beat_last;
  logic [VL_W-1:0] elem_base;
  logic            busy;
  logic            illegal;

  modport master (
    output issue_valid, vs1_addr, vs2_addr, vd_addr, vsew, vlmul, vill,
           vl, vstart, is_reduct, is_mask, is_scalar_op, exe_stall,
    input  issue_ready, exe_valid, rf_rd_addr_srca, rf_rd_addr_srcb,
           rf_wr_addr, rf_wr_en, beat_idx, beat_first, beat_last,
           elem_base, busy, illegal
  );

  modport slave (
    input  issue_valid, vs1_addr, vs2_addr, vd_addr, vsew, vlmul, vill,
           vl, vstart, is_reduct, is_mask, is_scalar_op, exe_stall,
    output issue_ready, exe_valid, rf_rd_addr_srca, rf_rd_addr_srcb,
           rf_wr_addr, rf_wr_en, beat_idx, beat_first, beat_last,
           elem_base, busy, illegal
  );
endinterface

`default_nettype wire

// File: rtl/riscv_v_exe_seq.sv
// +----------------------------------------------------------------------------+
// | Module   : riscv_v_exe_seq                                                  |
// | Purpose  : Walks one vector instruction's register group, one beat/cycle.   |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module riscv_v_exe_seq #(
  parameter int VLEN      = 128,
  parameter int NUM_VREGS = 32,
  parameter int MAX_LMUL  = 8,
  parameter int VL_W      = $clog2(VLEN*MAX_LMUL/8)+1
) (
  input  wire logic        clk,
  input  wire logic        rst,
  riscv_v_exe_seq_if.slave io_bus
);

  localparam int c_AW       = $clog2(NUM_VREGS);
  localparam int c_BW       = $clog2(MAX_LMUL);
  localparam int c_LOG_VLEN = $clog2(VLEN);

  typedef logic [c_AW-1:0] addr_t;
  typedef logic [c_BW-1:0] beat_t;
  typedef logic [c_BW:0]   nreg_t;
  typedef logic [VL_W-1:0] vl_t;
  typedef logic [VL_W:0]   ext_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t r_state;
  addr_t  r_vs1, r_vs2, r_vd;
  logic   r_red, r_scal;
  logic [7:0] r_lg;
  beat_t  r_last;
  logic   r_exe_valid, r_wr_en, r_first, r_beat_last, r_illegal;
  addr_t  r_srca, r_srcb, r_wr;
  beat_t  r_beat;
  vl_t    r_eb;

  // Elements per register is a power of two, so divisions become shifts by log2(EPR)
  logic [7:0] w_epr_lg;
  ext_t       w_epr, w_ceil, w_cnt;
  vl_t        w_first_full;
  nreg_t      w_nreg;
  addr_t      w_amask;
  logic       w_zero, w_illegal;
  beat_t      w_new_first, w_new_last;

  assign w_epr_lg     = 8'(c_LOG_VLEN - 3) - {5'd0, io_bus.vsew};
  assign w_epr        = ext_t'(1) << w_epr_lg;
  assign w_ceil       = (ext_t'(io_bus.vl) + w_epr - ext_t'(1)) >> w_epr_lg;
  assign w_first_full = io_bus.vstart >> w_epr_lg;
  assign w_nreg       = io_bus.vlmul[2] ? nreg_t'(1) : (nreg_t'(1) << io_bus.vlmul[1:0]);
  assign w_cnt        = (w_ceil < ext_t'(w_nreg)) ? w_ceil : ext_t'(w_nreg);
  assign w_amask      = addr_t'(w_nreg - nreg_t'(1));

  // A start register past the group end leaves nothing to issue
  assign w_zero = (io_bus.vl == '0) || (io_bus.vstart >= io_bus.vl) ||
                  (!io_bus.is_mask && (ext_t'(w_first_full) >= w_cnt));
  assign w_new_first = io_bus.is_mask ? '0 : beat_t'(w_first_full);
  assign w_new_last  = io_bus.is_mask ? '0 : beat_t'(w_cnt - ext_t'(1));

  assign w_illegal = io_bus.vill || io_bus.vsew[2] || (io_bus.vlmul == 3'd4) ||
                     (io_bus.is_reduct && (io_bus.vstart != '0)) ||
                     ((io_bus.vs2_addr & w_amask) != '0) ||
                     (!io_bus.is_reduct && ((io_bus.vd_addr & w_amask) != '0)) ||
                     (!(io_bus.is_reduct || io_bus.is_scalar_op) &&
                      ((io_bus.vs1_addr & w_amask) != '0));

  logic w_adv, w_ready, w_accept, w_load;

  assign w_adv    = (r_state == ST_RUN) && !io_bus.exe_stall;
  assign w_ready  = !rst && ((r_state == ST_IDLE) || (w_adv && r_beat_last));
  assign w_accept = io_bus.issue_valid && w_ready;
  assign w_load   = w_accept && !w_illegal && !w_zero;

  // Next-beat fields come from the new instruction on a load, else from the held one
  beat_t      w_b, w_s_last;
  addr_t      w_s_vs1, w_s_vs2, w_s_vd;
  logic       w_s_red, w_s_scal;
  logic [7:0] w_s_lg;
  addr_t      w_nxt_srca, w_nxt_srcb, w_nxt_wr;
  logic       w_nxt_last;
  vl_t        w_nxt_eb;

  assign w_b      = w_load ? w_new_first : (r_beat + beat_t'(1));
  assign w_s_last = w_load ? w_new_last : r_last;
  assign w_s_vs1  = w_load ? io_bus.vs1_addr : r_vs1;
  assign w_s_vs2  = w_load ? io_bus.vs2_addr : r_vs2;
  assign w_s_vd   = w_load ? io_bus.vd_addr : r_vd;
  assign w_s_red  = w_load ? io_bus.is_reduct : r_red;
  assign w_s_scal = w_load ? io_bus.is_scalar_op : r_scal;
  assign w_s_lg   = w_load ? w_epr_lg : r_lg;

  assign w_nxt_srca = w_s_vs2 + addr_t'(w_b);
  assign w_nxt_srcb = (w_s_red || w_s_scal) ? w_s_vs1 : (w_s_vs1 + addr_t'(w_b));
  assign w_nxt_wr   = w_s_red ? w_s_vd : (w_s_vd + addr_t'(w_b));
  assign w_nxt_last = (w_b == w_s_last);
  assign w_nxt_eb   = vl_t'(w_b) << w_s_lg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_vs1       <= '0;
      r_vs2       <= '0;
      r_vd        <= '0;
      r_red       <= 1'b0;
      r_scal      <= 1'b0;
      r_lg        <= '0;
      r_last      <= '0;
      r_exe_valid <= 1'b0;
      r_wr_en     <= 1'b0;
      r_first     <= 1'b0;
      r_beat_last <= 1'b0;
      r_illegal   <= 1'b0;
      r_srca      <= '0;
      r_srcb      <= '0;
      r_wr        <= '0;
      r_beat      <= '0;
      r_eb        <= '0;
    end else begin
      r_illegal <= 1'b0;
      if (w_load) begin
        r_state     <= ST_RUN;
        r_vs1       <= io_bus.vs1_addr;
        r_vs2       <= io_bus.vs2_addr;
        r_vd        <= io_bus.vd_addr;
        r_red       <= io_bus.is_reduct;
        r_scal      <= io_bus.is_scalar_op;
        r_lg        <= w_epr_lg;
        r_last      <= w_new_last;
        r_exe_valid <= 1'b1;
        r_first     <= 1'b1;
        r_beat      <= w_b;
        r_beat_last <= w_nxt_last;
        r_wr_en     <= !w_s_red || w_nxt_last;
        r_srca      <= w_nxt_srca;
        r_srcb      <= w_nxt_srcb;
        r_wr        <= w_nxt_wr;
        r_eb        <= w_nxt_eb;
      end else if (w_accept || (w_adv && r_beat_last)) begin
        r_state     <= ST_IDLE;
        r_exe_valid <= 1'b0;
        r_first     <= 1'b0;
        r_beat      <= '0;
        r_beat_last <= 1'b0;
        r_wr_en     <= 1'b0;
        r_srca      <= '0;
        r_srcb      <= '0;
        r_wr        <= '0;
        r_eb        <= '0;
        r_illegal   <= w_accept && w_illegal;
      end else if (w_adv) begin
        r_first     <= 1'b0;
        r_beat      <= w_b;
        r_beat_last <= w_nxt_last;
        r_wr_en     <= !w_s_red || w_nxt_last;
        r_srca      <= w_nxt_srca;
        r_srcb      <= w_nxt_srcb;
        r_wr        <= w_nxt_wr;
        r_eb        <= w_nxt_eb;
      end
    end
  end

  assign io_bus.issue_ready     = w_ready;
  assign io_bus.exe_valid       = r_exe_valid;
  assign io_bus.rf_rd_addr_srca = r_srca;
  assign io_bus.rf_rd_addr_srcb = r_srcb;
  assign io_bus.rf_wr_addr      = r_wr;
  assign io_bus.rf_wr_en        = r_wr_en;
  assign io_bus.beat_idx        = r_beat;
  assign io_bus.beat_first      = r_first;
  assign io_bus.beat_last       = r_beat_last;
  assign io_bus.elem_base       = r_eb;
  assign io_bus.busy            = (r_state == ST_RUN);
  assign io_bus.illegal         = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_riscv_v_exe_seq.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_riscv_v_exe_seq                                               |
// | Purpose  : Vector table, corner sequences and random run vs. queue model.   |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_riscv_v_exe_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  riscv_v_exe_seq_if #(.VLEN(128), .MAX_LMUL(8)) bif ();

  riscv_v_exe_seq #(.VLEN(128), .NUM_VREGS(32), .MAX_LMUL(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bif.slave)
  );

  typedef struct packed {
    logic       valid;
    logic [4:0] srca;
    logic [4:0] srcb;
    logic [4:0] wr;
    logic       wr_en;
    logic [2:0] idx;
    logic       first;
    logic       last;
    logic [7:0] eb;
    logic       busy;
    logic       ill;
  } obs_t;

  typedef struct {
    int vsew, vlmul, vl, vstart, vs2, vs1, vd;
    bit red, mask, scal, vill;
  } ins_t;

  typedef struct {
    ins_t ins;
    int   beats, fidx, srca0, lastwr;
    bit   ill;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  obs_t cur;
  obs_t q[$];

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.valid = bif.exe_valid;
    o.srca  = bif.rf_rd_addr_srca;
    o.srcb  = bif.rf_rd_addr_srcb;
    o.wr    = bif.rf_wr_addr;
    o.wr_en = bif.rf_wr_en;
    o.idx   = bif.beat_idx;
    o.first = bif.beat_first;
    o.last  = bif.beat_last;
    o.eb    = bif.elem_base;
    o.busy  = bif.busy;
    o.ill   = bif.illegal;
    return o;
  endfunction

  function automatic ins_t mk(int vsew, int vlmul, int vl, int vstart, int vs2, int vs1,
                              int vd, bit red, bit mask, bit scal, bit vill);
    ins_t i;
    i.vsew = vsew; i.vlmul = vlmul; i.vl = vl; i.vstart = vstart;
    i.vs2 = vs2; i.vs1 = vs1; i.vd = vd;
    i.red = red; i.mask = mask; i.scal = scal; i.vill = vill;
    return i;
  endfunction

  task automatic drive(ins_t i, bit iv);
    bif.issue_valid  = iv;
    bif.vsew         = 3'(i.vsew);
    bif.vlmul        = 3'(i.vlmul);
    bif.vill         = i.vill;
    bif.vl           = 8'(i.vl);
    bif.vstart       = 8'(i.vstart);
    bif.vs1_addr     = 5'(i.vs1);
    bif.vs2_addr     = 5'(i.vs2);
    bif.vd_addr      = 5'(i.vd);
    bif.is_reduct    = i.red;
    bif.is_mask      = i.mask;
    bif.is_scalar_op = i.scal;
  endtask

  // Reference model: group size and element counts straight from vtype arithmetic
  function automatic int nreg_of(int lm);
    return (lm <= 3) ? (1 << lm) : 1;
  endfunction

  function automatic bit is_illegal(ins_t i);
    int n = nreg_of(i.vlmul);
    if (i.vill || i.vsew > 3 || i.vlmul == 4) return 1'b1;
    if (i.red && i.vstart != 0) return 1'b1;
    if (i.vs2 % n != 0) return 1'b1;
    if (!i.red && (i.vd % n != 0)) return 1'b1;
    if (!(i.red || i.scal) && (i.vs1 % n != 0)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void fill(ins_t i);
    int epr, fst, lst, ce;
    obs_t o;
    q.delete();
    if (i.vl == 0 || i.vstart >= i.vl) return;
    epr = 128 >> (3 + i.vsew);
    if (i.mask) begin
      fst = 0; lst = 0;
    end else begin
      fst = i.vstart / epr;
      ce  = (i.vl + epr - 1) / epr;
      lst = ((ce < nreg_of(i.vlmul)) ? ce : nreg_of(i.vlmul)) - 1;
    end
    for (int b = fst; b <= lst; b++) begin
      o.valid = 1'b1;
      o.srca  = 5'((i.vs2 + b) % 32);
      o.srcb  = (i.red || i.scal) ? 5'(i.vs1) : 5'((i.vs1 + b) % 32);
      o.wr    = i.red ? 5'(i.vd) : 5'((i.vd + b) % 32);
      o.last  = (b == lst);
      o.wr_en = !i.red || (b == lst);
      o.idx   = 3'(b);
      o.first = (b == fst);
      o.eb    = 8'(b * epr);
      o.busy  = 1'b1;
      o.ill   = 1'b0;
      q.push_back(o);
    end
  endfunction

  function automatic ins_t rnd_ins();
    ins_t i;
    int n, epr, vlmax;
    i.vsew  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
    i.vlmul = int'($urandom_range(0, 7));
    n       = nreg_of(i.vlmul);
    epr     = (i.vsew <= 3) ? (128 >> (3 + i.vsew)) : 16;
    vlmax   = (i.vlmul <= 3) ? n * epr : epr;
    i.mask  = ($urandom_range(0, 9) == 0);
    i.red   = ($urandom_range(0, 4) == 0);
    i.scal  = ($urandom_range(0, 3) == 0);
    i.vill  = ($urandom_range(0, 32) == 0);
    i.vl    = int'($urandom_range(0, vlmax));
    i.vstart = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(0, i.vl));
    if (i.mask) begin
      if (i.vl == 0) i.vl = 1;
      if (i.vstart >= i.vl) i.vstart = 0;
    end
    i.vs2 = int'($urandom_range(0, 31));
    i.vs1 = int'($urandom_range(0, 31));
    i.vd  = int'($urandom_range(0, 31));
    if ($urandom_range(0, 19) != 0) begin
      i.vs2 = i.vs2 - (i.vs2 % n);
      i.vs1 = i.vs1 - (i.vs1 % n);
      i.vd  = i.vd - (i.vd % n);
    end
    return i;
  endfunction

  vec_t vt[16];
  ins_t c1, c2, ri;

  initial begin
    obs_t o;
    int beats, fidx, srca0, lastwr;
    bit ill_seen, exp_rdy, acc;

    vt[0]  = '{mk(2,2,16,0,8,16,4,0,0,0,0), 4,  0,  8,  7, 1'b0};
    vt[1]  = '{mk(2,2,9,4,8,16,4,0,0,0,0),  2,  1,  9,  6, 1'b0};
    vt[2]  = '{mk(0,1,32,0,2,10,0,1,0,0,0), 2,  0,  2,  0, 1'b0};
    vt[3]  = '{mk(0,1,32,1,2,10,0,1,0,0,0), 0, -1, -1, -1, 1'b1};
    vt[4]  = '{mk(2,1,8,0,0,0,3,0,0,0,0),   0, -1, -1, -1, 1'b1};
    vt[5]  = '{mk(2,2,0,0,8,16,4,0,0,0,0),  0, -1, -1, -1, 1'b0};
    vt[6]  = '{mk(0,3,100,0,8,16,24,0,1,0,0), 1, 0, 8, 24, 1'b0};
    vt[7]  = '{mk(3,7,2,0,5,7,9,0,0,0,0),   1,  0,  5,  9, 1'b0};
    vt[8]  = '{mk(4,0,4,0,0,0,0,0,0,0,0),   0, -1, -1, -1, 1'b1};
    vt[9]  = '{mk(2,4,4,0,0,0,0,0,0,0,0),   0, -1, -1, -1, 1'b1};
    vt[10] = '{mk(2,0,4,0,0,0,0,0,0,0,1),   0, -1, -1, -1, 1'b1};
    vt[11] = '{mk(2,1,8,0,2,3,6,0,0,1,0),   2,  0,  2,  7, 1'b0};
    vt[12] = '{mk(2,0,4,4,1,1,1,0,0,0,0),   0, -1, -1, -1, 1'b0};
    vt[13] = '{mk(3,0,4,0,31,30,29,0,0,0,0), 1, 0, 31, 29, 1'b0};
    vt[14] = '{mk(2,1,8,0,2,3,6,0,0,0,0),   0, -1, -1, -1, 1'b1};
    vt[15] = '{mk(1,2,32,0,4,5,7,1,0,0,0), 4,  0,  4,  7, 1'b0};
    c1 = vt[0].ins;
    c2 = vt[1].ins;

    // Reset state, with a request pending that must not be taken
    rst = 1'b1;
    bif.exe_stall = 1'b0;
    drive(c1, 1'b1);
    tick();
    tick();
    chk("reset_outputs", int'(sample()), 0);
    chk("reset_ready", int'(bif.issue_ready), 0);
    rst = 1'b0;
    drive(c1, 1'b0);
    tick();

    for (int k = 0; k < 16; k++) begin
      beats = 0; fidx = -1; srca0 = -1; lastwr = -1; ill_seen = 1'b0;
      drive(vt[k].ins, 1'b1);
      for (int c = 0; c < 12; c++) begin
        tick();
        if (c == 0) bif.issue_valid = 1'b0;
        if (bif.exe_valid) begin
          if (beats == 0) begin
            fidx  = int'(bif.beat_idx);
            srca0 = int'(bif.rf_rd_addr_srca);
          end
          beats++;
          if (bif.rf_wr_en) lastwr = int'(bif.rf_wr_addr);
        end
        if (bif.illegal) ill_seen = 1'b1;
      end
      chk($sformatf("vec%0d_beats", k), beats, vt[k].beats);
      chk($sformatf("vec%0d_first_idx", k), fidx, vt[k].fidx);
      chk($sformatf("vec%0d_srca0", k), srca0, vt[k].srca0);
      chk($sformatf("vec%0d_last_wr", k), lastwr, vt[k].lastwr);
      chk($sformatf("vec%0d_illegal", k), int'(ill_seen), int'(vt[k].ill));
    end

    // Stall two cycles on beat 1: beat 1 held for three samples
    drive(c1, 1'b1);
    tick();
    bif.issue_valid = 1'b0;
    chk("stall_b0_srca", int'(bif.rf_rd_addr_srca), 8);
    tick();
    bif.exe_stall = 1'b1;
    chk("stall_b1_srca", int'(bif.rf_rd_addr_srca), 9);
    tick();
    chk("stall_hold1_srca", int'(bif.rf_rd_addr_srca), 9);
    chk("stall_hold1_eb", int'(bif.elem_base), 4);
    tick();
    chk("stall_hold2_idx", int'(bif.beat_idx), 1);
    chk("stall_ready_low", int'(bif.issue_ready), 0);
    bif.exe_stall = 1'b0;
    tick();
    chk("stall_b2_srca", int'(bif.rf_rd_addr_srca), 10);
    tick();
    chk("stall_b3_last", int'(bif.beat_last), 1);
    chk("stall_b3_ready", int'(bif.issue_ready), 1);
    tick();
    chk("stall_done_busy", int'(bif.busy), 0);

    // Back-to-back issue during the last beat
    drive(c1, 1'b1);
    tick();
    bif.issue_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("b2b_b3_wr", int'(bif.rf_wr_addr), 7);
    drive(c2, 1'b1);
    #1;
    chk("b2b_ready", int'(bif.issue_ready), 1);
    tick();
    bif.issue_valid = 1'b0;
    chk("b2b_nobubble_valid", int'(bif.exe_valid), 1);
    chk("b2b_srca", int'(bif.rf_rd_addr_srca), 9);
    chk("b2b_first", int'(bif.beat_first), 1);
    tick();
    chk("b2b_last", int'(bif.beat_last), 1);
    tick();

    // Reset in the middle of an instruction
    drive(c1, 1'b1);
    tick();
    bif.issue_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_outputs", int'(sample()), 0);
    rst = 1'b0;
    tick();
    chk("midrst_stays_idle", int'(bif.exe_valid), 0);

    // Zero-length instruction leaves the sequencer ready
    drive(vt[5].ins, 1'b1);
    tick();
    bif.issue_valid = 1'b0;
    #1;
    chk("vl0_ready", int'(bif.issue_ready), 1);
    chk("vl0_busy", int'(bif.busy), 0);

    // Random traffic against the queue model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cur = '0;
    q.delete();
    for (int c = 0; c < 600; c++) begin
      ri = rnd_ins();
      drive(ri, ($urandom_range(0, 9) < 6));
      rst = ($urandom_range(0, 99) == 0);
      bif.exe_stall = cur.valid && ($urandom_range(0, 3) == 0);
      #1;
      exp_rdy = !rst && (!cur.valid || (cur.last && !bif.exe_stall));
      chk($sformatf("rand%0d_ready", c), int'(bif.issue_ready), int'(exp_rdy));
      acc = bif.issue_valid && exp_rdy;
      if (rst) begin
        cur = '0;
        q.delete();
      end else if (acc) begin
        cur = '0;
        if (is_illegal(ri)) begin
          q.delete();
          cur.ill = 1'b1;
        end else begin
          fill(ri);
          if (q.size() > 0) cur = q.pop_front();
        end
      end else if (cur.valid && !bif.exe_stall) begin
        cur = (q.size() > 0) ? q.pop_front() : '0;
      end else if (!cur.valid) begin
        cur = '0;
      end
      tick();
      o = sample();
      n_cmp++;
      if (o != cur) begin
        n_bad++;
        $display("FAIL rand%0d_outputs: got %h expected %h", c, o, cur);
      end
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
